cla_nibble_seq: RTL and testbench

- Multi-cycle sequencer that adds WIDTH-bit operands using one shared 4-bit carry-lookahead nibble adder.
- Slices the operands into nibbles, LSB first, and drives one nibble per cycle into the external adder, chaining carry between nibbles.
- Accepts a request with a valid/ready handshake and returns the full sum and carry-out with valid/ready.
- Sits between a requester and the 4-bit CLA datapath; the adder itself is outside this block.

---
 rtl/cla_nibble_seq.sv | 155 +++++++++++++++
 tb/tb_cla_nibble_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_seq.sv
// ============================================================================
// cla_nibble_seq : WIDTH-bit add, one 4-bit nibble per cycle through an
//                  external carry-lookahead adder (optional overflow output
//                  via CLA_NIBBLE_SEQ_OVF_EN)
// Revision 1.0
// ============================================================================
`default_nettype none

module cla_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy,
    output logic [3:0]       nib_a,
    output logic [3:0]       nib_b,
    output logic             nib_cin,
    input  logic [3:0]       nib_sum,
    input  logic             nib_cout
`ifdef CLA_NIBBLE_SEQ_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int NIBS = WIDTH / 4;
    localparam int IDXW = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        nib_a     = 4'd0;
        nib_b     = 4'd0;
        nib_cin   = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                nib_cin = carry_q;
                // Constant-indexed mux keeps every slice in range for any WIDTH
                for (int i = 0; i < NIBS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        nib_a              = a_q[4*i +: 4];
                        nib_b              = b_q[4*i +: 4];
                        sum_d[4*i +: 4]    = nib_sum;
                    end
                end
                carry_d = nib_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = nib_cout;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (nib_sum[3] != a_q[WIDTH-1]);
`endif
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
    assign out_ovf  = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cla_nibble_seq.sv
// ============================================================================
// tb_cla_nibble_seq : randomized + directed bench for cla_nibble_seq
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cla_nibble_seq;

    localparam int WIDTH = 16;
    localparam int NIBS  = WIDTH / 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] in_a      = '0;
    logic [WIDTH-1:0] in_b      = '0;
    logic             in_cin    = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic             nib_cin;
    logic [3:0]       nib_sum;
    logic             nib_cout;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
    logic             out_ovf;
    logic             cap_ovf;
`endif

    int checks = 0;
    int errors = 0;

    cla_nibble_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy),
        .nib_a     (nib_a),
        .nib_b     (nib_b),
        .nib_cin   (nib_cin),
        .nib_sum   (nib_sum),
        .nib_cout  (nib_cout)
`ifdef CLA_NIBBLE_SEQ_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    // External 4-bit adder the sequencer drives
    assign {nib_cout, nib_sum} = 5'(nib_a) + 5'(nib_b) + 5'(nib_cin);

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] full_sum(input logic [15:0] a, input logic [15:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {16'd0, c};
    endfunction

    function automatic logic [3:0] nibble(input logic [15:0] v, input int k);
        logic [15:0] t;
        t = v >> (4 * k);
        return t[3:0];
    endfunction

    // Carry entering nibble k = carry out of the sum of the lower 4k bits
    function automatic logic carry_into(input logic [15:0] a, input logic [15:0] b, input logic c, input int k);
        logic [16:0] m;
        logic [16:0] t;
        m = (17'd1 << (4 * k)) - 17'd1;
        t = ({1'b0, a} & m) + ({1'b0, b} & m) + {16'd0, c};
        t = t >> (4 * k);
        return t[0];
    endfunction

    // Model: a pending transaction and how many cycles have elapsed since acceptance
    logic        m_pend;
    int          m_cnt;
    logic [15:0] m_a, m_b;
    logic        m_cin;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0;
            m_cnt  <= 0;
            m_a    <= '0;
            m_b    <= '0;
            m_cin  <= 1'b0;
        end else if (!m_pend) begin
            if (in_valid) begin
                m_pend <= 1'b1;
                m_cnt  <= 0;
                m_a    <= in_a;
                m_b    <= in_b;
                m_cin  <= in_cin;
            end
        end else if (m_cnt < NIBS) begin
            m_cnt <= m_cnt + 1;
        end else if (out_ready) begin
            m_pend <= 1'b0;
        end
    end

    always @(negedge clk) begin : cmp
        logic        run_ph;
        logic        done_ph;
        logic [16:0] fs;
        run_ph  = m_pend && (m_cnt < NIBS);
        done_ph = m_pend && (m_cnt == NIBS);
        fs      = full_sum(m_a, m_b, m_cin);
        check("in_ready",  {31'd0, in_ready},  {31'd0, !m_pend});
        check("busy",      {31'd0, busy},      {31'd0, m_pend});
        check("out_valid", {31'd0, out_valid}, {31'd0, done_ph});
        check("nib_a",   {28'd0, nib_a}, {28'd0, run_ph ? nibble(m_a, m_cnt) : 4'd0});
        check("nib_b",   {28'd0, nib_b}, {28'd0, run_ph ? nibble(m_b, m_cnt) : 4'd0});
        check("nib_cin", {31'd0, nib_cin},
              {31'd0, run_ph ? carry_into(m_a, m_b, m_cin, m_cnt) : 1'b0});
        if (done_ph) begin
            check("out_sum",  {16'd0, out_sum},  {16'd0, fs[15:0]});
            check("out_cout", {31'd0, out_cout}, {31'd0, fs[16]});
`ifdef CLA_NIBBLE_SEQ_OVF_EN
            check("out_ovf", {31'd0, out_ovf},
                  {31'd0, (m_a[15] == m_b[15]) && (fs[15] != m_a[15])});
`endif
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one request, collect the per-cycle nibble/carry stream, hold, release
    task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input int hold, input logic rnd_ready,
                          output logic [15:0] s, output logic co,
                          output logic [15:0] nseq, output logic [3:0] cseq);
        int n;
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        @(negedge clk);
        in_valid = 1'b0;
        nseq = '0;
        cseq = '0;
        n = 0;
        while (!out_valid && n < 20) begin
            if (n < 4) begin
                nseq[4*n +: 4] = nib_a;
                cseq[n]        = nib_cin;
            end
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            n++;
            @(negedge clk);
        end
        check("run_cycles", n, NIBS);
        out_ready = 1'b0;
        s  = out_sum;
        co = out_cout;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
        cap_ovf = out_ovf;
`endif
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        logic        co;
        logic [15:0] nseq;
        logic [3:0]  cseq;
        int          n;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum",   {16'd0, out_sum},   32'd0);
        check("rst_out_cout",  {31'd0, out_cout},  32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_nib",       {23'd0, nib_a, nib_b, nib_cin}, 32'd0);
        rst_n = 1'b1;

        do_txn(16'h1234, 16'h4321, 1'b0, 0, 1'b0, s, co, nseq, cseq);
        check("t1_sum", {16'd0, s}, 32'h5555);
        check("t1_cout", {31'd0, co}, 32'd0);
        check("t1_nib_a_seq", {16'd0, nseq}, 32'h1234);

        do_txn(16'hFFFF, 16'h0001, 1'b0, 1, 1'b0, s, co, nseq, cseq);
        check("t2_sum", {16'd0, s}, 32'h0000);
        check("t2_cout", {31'd0, co}, 32'd1);
        check("t2_nib_cin_seq", {28'd0, cseq}, 32'b1110);

        do_txn(16'h0000, 16'h0000, 1'b1, 0, 1'b0, s, co, nseq, cseq);
        check("t3a_sum", {16'd0, s}, 32'h0001);
        check("t3a_cout", {31'd0, co}, 32'd0);
        do_txn(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0, s, co, nseq, cseq);
        check("t3b_sum", {16'd0, s}, 32'h0000);
        check("t3b_cout", {31'd0, co}, 32'd1);

        // Backpressure with a queued request waiting behind the result
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_a = 16'h0101; in_b = 16'h0202;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
            check("bp_sum", {16'd0, out_sum}, 32'h3333);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("bp_accept_next", {31'd0, busy}, 32'd1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        check("bp_next_sum", {16'd0, out_sum}, 32'h0303);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the second RUN cycle
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy",      {31'd0, busy},      32'd0);
        check("mid_rst_nib",       {23'd0, nib_a, nib_b, nib_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(16'h000A, 16'h0005, 1'b0, 0, 1'b0, s, co, nseq, cseq);
        check("post_rst_sum", {16'd0, s}, 32'h000F);

`ifdef CLA_NIBBLE_SEQ_OVF_EN
        do_txn(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, s, co, nseq, cseq);
        check("ovf1_sum", {16'd0, s}, 32'h8000);
        check("ovf1_ovf", {31'd0, cap_ovf}, 32'd1);
        check("ovf1_cout", {31'd0, co}, 32'd0);
        do_txn(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, s, co, nseq, cseq);
        check("ovf2_ovf", {31'd0, cap_ovf}, 32'd0);
`endif

        for (int t = 0; t < 60; t++) begin
            logic [15:0] ra, rb;
            logic [16:0] fs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (t % 10 == 3) ra = 16'hFFFF;
            if (t % 10 == 7) rb = ~ra;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_txn(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1,
                   s, co, nseq, cseq);
            fs = full_sum(ra, rb, 1'b0);
            check("rnd_nib_a_seq", {16'd0, nseq}, {16'd0, ra});
            check("rnd_sum_bits", {15'd0, co, s} - (fs & 17'h1FFFF), {31'd0, cseq[0]});
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
